regfile_scoreboard: RTL and testbench

Parametrised successor to the SimpleRisc 16x32 register file, used in the pipelined core's operand-fetch stage.
- Decodes source addresses from the instruction word, including the ret (ra) and store (rd as op2) overrides.
- Delivers registered operands with one-cycle latency.
- Tracks in-flight destinations in a busy scoreboard and raises stall on RAW hazards.
- Counts stall cycles for performance monitoring.

---
 rtl/regfile_scoreboard_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 98 +++++++++
 tb/tb_regfile_scoreboard.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - operand-fetch bus between the pipeline and the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic [31:0]         instruction;
  logic                is_ret;
  logic                is_st;
  logic                rd_en;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_adr;
  logic                is_wb;
  logic [ADDR_W-1:0]   wr_adr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   op1;
  logic [DATA_W-1:0]   op2;
  logic                op_valid;
  logic                stall;
  logic [NUM_REGS-1:0] busy;
  logic [15:0]         stall_cnt;

  modport master (
    output instruction, is_ret, is_st, rd_en, issue_en, issue_adr,
    output is_wb, wr_adr, wr_data,
    input  op1, op2, op_valid, stall, busy, stall_cnt
  );

  modport slave (
    input  instruction, is_ret, is_st, rd_en, issue_en, issue_adr,
    input  is_wb, wr_adr, wr_data,
    output op1, op2, op_valid, stall, busy, stall_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with busy scoreboard, RAW stall and stall counter
// Optional writeback-to-operand forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int RA_IDX   = 15,
  parameter int RD_LSB   = 22,
  parameter int RS1_LSB  = 18,
  parameter int RS2_LSB  = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam logic [ADDR_W-1:0] RA_ADR = ADDR_W'(RA_IDX);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic                op_valid_q;
  logic [15:0]         stall_cnt_q;

  logic [ADDR_W-1:0]   a1;
  logic [ADDR_W-1:0]   a2;
  logic                fwd1;
  logic                fwd2;
  logic                haz1;
  logic                haz2;
  logic                stall_w;
  logic [DATA_W-1:0]   val1;
  logic [DATA_W-1:0]   val2;

  always_comb begin
    a1 = bus.is_ret ? RA_ADR : bus.instruction[RS1_LSB +: ADDR_W];
    a2 = bus.is_st  ? bus.instruction[RD_LSB +: ADDR_W] : bus.instruction[RS2_LSB +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    fwd1 = bus.is_wb && (bus.wr_adr == a1);
    fwd2 = bus.is_wb && (bus.wr_adr == a2);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    haz1    = busy_q[a1] & ~fwd1;
    haz2    = busy_q[a2] & ~fwd2;
    stall_w = bus.rd_en & (haz1 | haz2);
    val1    = fwd1 ? bus.wr_data : regs[a1];
    val2    = fwd2 ? bus.wr_data : regs[a2];
  end

  // Clear before set so a same-cycle issue to the writeback address stays pending.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.is_wb) begin
      busy_nxt[bus.wr_adr] = 1'b0;
    end
    if (bus.issue_en && !stall_w) begin
      busy_nxt[bus.issue_adr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.is_wb) begin
        regs[bus.wr_adr] <= bus.wr_data;
      end
      busy_q <= busy_nxt;
      if (bus.rd_en && !stall_w) begin
        op1_q      <= val1;
        op2_q      <= val2;
        op_valid_q <= 1'b1;
      end else begin
        op_valid_q <= 1'b0;
      end
      if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.stall     = stall_w;
  assign bus.busy      = busy_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) bus ();

  regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: architectural view only
  int          m_regs [NR];
  logic [15:0] m_busy;
  int          m_cnt;
  int          m_op1;
  int          m_op2;
  bit          m_valid;

  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit ret;
    bit st;
    int e1;
    int e2;
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rd, input int rs1, input int rs2);
    return (32'(rd) << 22) | (32'(rs1) << 18) | (32'(rs2) << 14);
  endfunction

  function automatic bit m_forwards(input int a);
    return BYP && bus.is_wb && (int'(bus.wr_adr) == a);
  endfunction

  function automatic bit m_hazard(input int a);
    return m_busy[a] && !m_forwards(a);
  endfunction

  function automatic int m_value(input int a);
    return m_forwards(a) ? int'(bus.wr_data) : m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_busy  = '0;
    m_cnt   = 0;
    m_op1   = 0;
    m_op2   = 0;
    m_valid = 1'b0;
  endtask

  task automatic idle();
    bus.instruction = '0;
    bus.is_ret      = 1'b0;
    bus.is_st       = 1'b0;
    bus.rd_en       = 1'b0;
    bus.issue_en    = 1'b0;
    bus.issue_adr   = '0;
    bus.is_wb       = 1'b0;
    bus.wr_adr      = '0;
    bus.wr_data     = '0;
  endtask

  // One clock: check stall before the edge, advance the model, check registered outputs after it
  task automatic step();
    int s1, s2, v1, v2;
    bit st;
    #1;
    s1 = bus.is_ret ? 15 : int'((bus.instruction >> 18) & 32'hF);
    s2 = bus.is_st ? int'((bus.instruction >> 22) & 32'hF) : int'((bus.instruction >> 14) & 32'hF);
    st = bus.rd_en && (m_hazard(s1) || m_hazard(s2));
    v1 = m_value(s1);
    v2 = m_value(s2);
    chk("stall", bus.stall, 32'(st));
    @(posedge clk);
    if (bus.rd_en && !st) begin
      m_op1   = v1;
      m_op2   = v2;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (bus.is_wb) begin
      m_regs[bus.wr_adr] = int'(bus.wr_data);
      m_busy[bus.wr_adr] = 1'b0;
    end
    if (bus.issue_en && !st) m_busy[bus.issue_adr] = 1'b1;
    if (st && m_cnt < 65535) m_cnt++;
    #1;
    chk("op1", bus.op1, 32'(m_op1));
    chk("op2", bus.op2, 32'(m_op2));
    chk("op_valid", 32'(bus.op_valid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  initial begin
    vt[0] = '{rs1: 3,  rs2: 7,  rd: 0,  ret: 1'b0, st: 1'b0, e1: 30,  e2: 70};
    vt[1] = '{rs1: 9,  rs2: 1,  rd: 0,  ret: 1'b1, st: 1'b0, e1: 150, e2: 10};
    vt[2] = '{rs1: 0,  rs2: 2,  rd: 10, ret: 1'b0, st: 1'b1, e1: 0,   e2: 100};
    vt[3] = '{rs1: 12, rs2: 12, rd: 5,  ret: 1'b1, st: 1'b1, e1: 150, e2: 50};

    m_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op1", bus.op1, 32'h0);
    chk("rst_op2", bus.op2, 32'h0);
    chk("rst_valid", 32'(bus.op_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < NR; i++) begin
      bus.is_wb   = 1'b1;
      bus.wr_adr  = AW'(i);
      bus.wr_data = 32'(i * 10);
      step();
    end
    idle();

    for (int k = 0; k < 4; k++) begin
      bus.instruction = mk_instr(vt[k].rd, vt[k].rs1, vt[k].rs2);
      bus.is_ret      = vt[k].ret;
      bus.is_st       = vt[k].st;
      bus.rd_en       = 1'b1;
      step();
      chk("vec_op1", bus.op1, 32'(vt[k].e1));
      chk("vec_op2", bus.op2, 32'(vt[k].e2));
      chk("vec_valid", 32'(bus.op_valid), 32'h1);
    end
    idle();
    step();
    chk("vec_cnt", 32'(bus.stall_cnt), 32'h0);

    // RAW stall on reg5, then resolved by writeback
    bus.issue_en  = 1'b1;
    bus.issue_adr = 4'd5;
    step();
    idle();
    chk("issue_busy5", 32'(bus.busy[5]), 32'h1);
    bus.instruction = mk_instr(0, 5, 0);
    bus.rd_en       = 1'b1;
    repeat (3) begin
      step();
      chk("stall_seq_valid", 32'(bus.op_valid), 32'h0);
    end
    chk("stall_seq_cnt", 32'(bus.stall_cnt), 32'd3);
    bus.is_wb   = 1'b1;
    bus.wr_adr  = 4'd5;
    bus.wr_data = 32'd55;
    step();
`ifdef REGFILE_BYPASS_EN
    chk("wb_cycle_valid", 32'(bus.op_valid), 32'h1);
    chk("wb_cycle_op1", bus.op1, 32'd55);
    chk("wb_cycle_cnt", 32'(bus.stall_cnt), 32'd3);
`else
    chk("wb_cycle_valid", 32'(bus.op_valid), 32'h0);
    chk("wb_cycle_cnt", 32'(bus.stall_cnt), 32'd4);
`endif
    bus.is_wb = 1'b0;
    step();
    chk("after_wb_op1", bus.op1, 32'd55);
    chk("after_wb_valid", 32'(bus.op_valid), 32'h1);
    idle();

    // Same-cycle issue and writeback to reg4: set wins
    bus.issue_en  = 1'b1;
    bus.issue_adr = 4'd4;
    bus.is_wb     = 1'b1;
    bus.wr_adr    = 4'd4;
    bus.wr_data   = 32'd44;
    step();
    chk("same_cycle_busy4", 32'(bus.busy[4]), 32'h1);
    idle();

    for (int n = 0; n < 400; n++) begin
      bus.instruction = $urandom;
      bus.is_ret      = ($urandom_range(0, 3) == 0);
      bus.is_st       = ($urandom_range(0, 3) == 0);
      bus.rd_en       = ($urandom_range(0, 1) == 1);
      bus.issue_en    = ($urandom_range(0, 2) == 0);
      bus.issue_adr   = AW'($urandom_range(0, NR - 1));
      bus.is_wb       = ($urandom_range(0, 1) == 1);
      bus.wr_adr      = AW'($urandom_range(0, NR - 1));
      bus.wr_data     = $urandom;
      step();
    end
    idle();

    // Saturation of the stall counter
    bus.issue_en  = 1'b1;
    bus.issue_adr = 4'd6;
    step();
    idle();
    bus.instruction = mk_instr(6, 6, 6);
    bus.rd_en       = 1'b1;
    repeat (70000) step();
    chk("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    idle();

    // Reset asserted mid-stall with reg5 pending
    bus.issue_en  = 1'b1;
    bus.issue_adr = 4'd5;
    step();
    idle();
    bus.instruction = mk_instr(0, 5, 5);
    bus.rd_en       = 1'b1;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_valid", 32'(bus.op_valid), 32'h0);
    chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'h0);
    chk("mid_rst_stall", 32'(bus.stall), 32'h0);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    for (int k = 0; k < NR / 2; k++) begin
      bus.instruction = mk_instr(0, 2 * k, 2 * k + 1);
      bus.rd_en       = 1'b1;
      step();
      chk("post_rst_op1", bus.op1, 32'h0);
      chk("post_rst_op2", bus.op2, 32'h0);
      chk("post_rst_valid", 32'(bus.op_valid), 32'h1);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
